traffic_light_sequencer: RTL and testbench

Avalon-MM slave that sequences a red/yellow/green lamp set through programmable phase durations under Nios II control. Its `green` output is the signal sampled by the system's green-light input PIO. It raises an interrupt each time the cycle returns to red. It sits on the same Avalon bus and clock domain as the PIO peripherals.

---
 rtl/traffic_light_pkg.sv | 22 ++
 rtl/traffic_light_sequencer_if.sv | 20 ++
 rtl/traffic_light_sequencer_phase_timer.sv | 26 ++
 rtl/traffic_light_sequencer.sv | 163 ++++++++++++++++
 tb/tb_traffic_light_sequencer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/traffic_light_pkg.sv
// Shared encodings for the traffic light sequencer: FSM states, register
// addresses and CTRL/STATUS bit positions.
package traffic_light_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_RED    = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_GREEN  = 2'd1;
    localparam logic [1:0] ADDR_YELLOW = 2'd2;
    localparam logic [1:0] ADDR_RED    = 2'd3;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_IRQ_EN    = 1;
    localparam int CTRL_STATE_LSB = 4;
    localparam int CTRL_PEND      = 8;

endpackage

// File: rtl/traffic_light_sequencer_if.sv
// Avalon-MM slave bus carrying the sequencer's register accesses.
interface traffic_light_sequencer_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/traffic_light_sequencer_phase_timer.sv
// Loadable down-counter timing one lamp phase; done holds while the count is zero.
module phase_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/traffic_light_sequencer.sv
// Avalon-MM controlled red/yellow/green sequencer with programmable phase
// lengths and an interrupt on every return to red.
module traffic_light_sequencer
    import traffic_light_pkg::*;
#(
    parameter int               CNT_W      = 24,
    parameter logic [CNT_W-1:0] GREEN_DEF  = CNT_W'(500000),
    parameter logic [CNT_W-1:0] YELLOW_DEF = CNT_W'(100000),
    parameter logic [CNT_W-1:0] RED_DEF    = CNT_W'(500000)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    traffic_light_sequencer_if.slave  bus,
    output logic                      red,
    output logic                      yellow,
    output logic                      green,
    output logic                      irq
);

    state_t           state;
    state_t           state_next;
    logic             enable;
    logic             irq_en;
    logic             pending;
    logic [CNT_W-1:0] green_time;
    logic [CNT_W-1:0] yellow_time;
    logic [CNT_W-1:0] red_time;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_done;
    logic [31:0]      rdata;
    logic             wr;
    logic             rd;
    logic             unused_wdata;

    // A programmed length of zero still yields a one-cycle phase.
    function automatic logic [CNT_W-1:0] phase_load(input logic [CNT_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    assign wr           = bus.chipselect & ~bus.write_n;
    assign rd           = bus.chipselect &  bus.write_n;
    assign unused_wdata = ^bus.writedata;
    assign irq          = pending & irq_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable       <= 1'b0;
            irq_en       <= 1'b0;
            green_time   <= GREEN_DEF;
            yellow_time  <= YELLOW_DEF;
            red_time     <= RED_DEF;
            bus.readdata <= '0;
        end else begin
            if (wr) begin
                case (bus.address)
                    ADDR_CTRL: begin
                        enable <= bus.writedata[CTRL_EN];
                        irq_en <= bus.writedata[CTRL_IRQ_EN];
                    end
                    ADDR_GREEN:  green_time  <= bus.writedata[CNT_W-1:0];
                    ADDR_YELLOW: yellow_time <= bus.writedata[CNT_W-1:0];
                    ADDR_RED:    red_time    <= bus.writedata[CNT_W-1:0];
                endcase
            end
            if (rd) begin
                bus.readdata <= rdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.address)
            ADDR_CTRL: begin
                rdata[CTRL_EN]                = enable;
                rdata[CTRL_IRQ_EN]            = irq_en;
                rdata[CTRL_STATE_LSB +: 2]    = state;
                rdata[CTRL_PEND]              = pending;
            end
            ADDR_GREEN:  rdata[CNT_W-1:0] = green_time;
            ADDR_YELLOW: rdata[CNT_W-1:0] = yellow_time;
            ADDR_RED:    rdata[CNT_W-1:0] = red_time;
        endcase
    end

    // Timer loads happen on the same edge as the phase change, from the
    // TIME register value held before that edge.
    always_comb begin
        state_next = state;
        timer_load = 1'b0;
        timer_val  = phase_load(green_time);
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_GREEN;
                    timer_load = 1'b1;
                    timer_val  = phase_load(green_time);
                end
            end
            ST_GREEN: begin
                if (!enable || timer_done) begin
                    state_next = ST_YELLOW;
                    timer_load = 1'b1;
                    timer_val  = phase_load(yellow_time);
                end
            end
            ST_YELLOW: begin
                if (timer_done) begin
                    if (enable) begin
                        state_next = ST_RED;
                        timer_load = 1'b1;
                        timer_val  = phase_load(red_time);
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_RED: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (timer_done) begin
                    state_next = ST_GREEN;
                    timer_load = 1'b1;
                    timer_val  = phase_load(green_time);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    // Lamps decode from the next state so they change on the state edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            red     <= 1'b1;
            yellow  <= 1'b0;
            green   <= 1'b0;
            pending <= 1'b0;
        end else begin
            state  <= state_next;
            red    <= (state_next == ST_IDLE) || (state_next == ST_RED);
            yellow <= (state_next == ST_YELLOW);
            green  <= (state_next == ST_GREEN);
            if (state == ST_YELLOW && state_next == ST_RED) begin
                pending <= 1'b1;
            end else if (wr && bus.address == ADDR_CTRL && bus.writedata[CTRL_PEND]) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Directed bench for traffic_light_sequencer: register reset values, lamp
// sequencing, interrupt/W1C races, disable, zero-length phases and async reset.
module tb_traffic_light_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic red, yellow, green, irq;
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [2:0] LG = 3'b001;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LR = 3'b100;

    traffic_light_sequencer_if bus ();

    traffic_light_sequencer #(
        .CNT_W      (24),
        .GREEN_DEF  (24'd500000),
        .YELLOW_DEF (24'd100000),
        .RED_DEF    (24'd500000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .red     (red),
        .yellow  (yellow),
        .green   (green),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lamps();
        return {28'b0, irq, red, yellow, green};
    endfunction

    // Callers sit at a negedge; the access lands on the following posedge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        @(negedge clk);
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    // Lamp pattern for GREEN=3, YELLOW=2, RED=4, i cycles after enable.
    function automatic logic [2:0] seq_exp(input int i);
        int m;
        if (i == 0) return LR;
        m = (i - 1) % 9;
        if (m < 3) return LG;
        if (m < 5) return LY;
        return LR;
    endfunction

    // Lamp pattern for GREEN=0 then GREEN=7, YELLOW=2, RED=4.
    function automatic logic [2:0] g0_exp(input int i);
        if (i == 1) return LG;
        if (i <= 3) return LY;
        if (i <= 7) return LR;
        if (i <= 14) return LG;
        return LY;
    endfunction

    initial begin
        logic [31:0] d;
        logic        found;
        logic        prev_y, prev_g, prev_irq;

        bus.address    = 2'd0;
        bus.writedata  = 32'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        check("rst_lamps", lamps(), {28'b0, 1'b0, LR});
        bus_read(2'd0, d); check("rst_ctrl", d, 32'h0);
        bus_read(2'd1, d); check("rst_green_time", d, 32'd500000);
        bus_read(2'd2, d); check("rst_yellow_time", d, 32'd100000);
        bus_read(2'd3, d); check("rst_red_time", d, 32'd500000);

        bus_write(2'd1, 32'hFF00_0003);
        bus_write(2'd2, 32'd2);
        bus_write(2'd3, 32'd4);
        bus_read(2'd1, d); check("time_upper_ignored", d, 32'd3);

        bus_write(2'd0, 32'h1);
        for (int i = 0; i <= 12; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("seq%0d", i), lamps(), {28'b0, 1'b0, seq_exp(i)});
        end
        bus_read(2'd0, d); check("seq_status", d, 32'h111);

        bus_write(2'd0, 32'h103);
        check("irq_after_clear", {31'b0, irq}, 32'd0);
        found = 1'b0;
        prev_y = yellow; prev_irq = irq;
        for (int t = 0; t < 30 && !found; t++) begin
            prev_y = yellow; prev_irq = irq;
            @(negedge clk);
            if (red && prev_y) found = 1'b1;
        end
        check("irq_wait_red", {31'b0, found}, 32'd1);
        check("irq_before_red", {31'b0, prev_irq}, 32'd0);
        check("irq_at_red", {31'b0, irq}, 32'd1);
        bus_write(2'd0, 32'h103);
        check("irq_w1c", {31'b0, irq}, 32'd0);

        found = 1'b0;
        for (int t = 0; t < 30 && !found; t++) begin
            prev_g = green;
            @(negedge clk);
            if (yellow && prev_g) found = 1'b1;
        end
        check("wait_yellow", {31'b0, found}, 32'd1);
        @(negedge clk);
        bus_write(2'd0, 32'h103);
        check("w1c_race_irq", {31'b0, irq}, 32'd1);
        bus_write(2'd0, 32'h1);
        check("irq_en_off", {31'b0, irq}, 32'd0);
        bus_read(2'd0, d); check("pend_kept", d & 32'h103, 32'h101);

        bus_write(2'd0, 32'h100);
        repeat (15) @(negedge clk);
        bus_write(2'd0, 32'h100);
        bus_read(2'd0, d); check("idle_clear", d, 32'h0);

        bus_write(2'd1, 32'd10);
        bus_write(2'd0, 32'h1);
        check("dis_k", lamps(), {28'b0, 1'b0, LR});
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check($sformatf("dis_green%0d", i), lamps(), {28'b0, 1'b0, LG});
        end
        bus_write(2'd0, 32'h0);
        check("dis_green4", lamps(), {28'b0, 1'b0, LG});
        @(negedge clk); check("dis_yellow1", lamps(), {28'b0, 1'b0, LY});
        @(negedge clk); check("dis_yellow2", lamps(), {28'b0, 1'b0, LY});
        @(negedge clk); check("dis_idle", lamps(), {28'b0, 1'b0, LR});
        bus_read(2'd0, d); check("dis_status", d, 32'h0);
        check("dis_idle_hold", lamps(), {28'b0, 1'b0, LR});

        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'h1);
        bus_write(2'd1, 32'd7);
        check("g0_1", lamps(), {28'b0, 1'b0, g0_exp(1)});
        bus_read(2'd1, d); check("g0_rd_green", d, 32'd7);
        check("g0_2", lamps(), {28'b0, 1'b0, g0_exp(2)});
        for (int i = 3; i <= 15; i++) begin
            @(negedge clk);
            check($sformatf("g0_%0d", i), lamps(), {28'b0, 1'b0, g0_exp(i)});
        end

        #2 reset_n = 1'b0;
        #1;
        check("arst_lamps", lamps(), {28'b0, 1'b0, LR});
        check("arst_readdata", bus.readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus_read(2'd0, d); check("arst_ctrl", d, 32'h0);
        bus_read(2'd1, d); check("arst_green_time", d, 32'd500000);
        bus_read(2'd2, d); check("arst_yellow_time", d, 32'd100000);
        bus_read(2'd3, d); check("arst_red_time", d, 32'd500000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
